// File: rtl/uart_rx_driver_pkg.sv
// Shared constants, receiver state type and small helpers for the UART RX slice.
package uart_rx_driver_pkg;

  localparam int unsigned BYTE_LEN  = 8;
  localparam int unsigned BIT_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_driver_synchronizer.sv
// Multi-stage flop synchroniser for an asynchronous single-bit input.
module synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_driver.sv
// 8N1 UART receiver: mid-bit 3-sample majority voting, framing-error and break detection.
module uart_rx_driver
  import uart_rx_driver_pkg::*;
#(
  parameter int unsigned BAUD_PERIOD = 434
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rxd,
  output logic [BYTE_LEN-1:0] out,
  output logic                out_ready,
  output logic                frame_err,
  output logic                break_det
);

  localparam int unsigned CNT_W = clog2(BAUD_PERIOD) + 1;
  localparam int unsigned MID   = BAUD_PERIOD / 2;

  localparam logic [CNT_W-1:0]     CNT_LAST      = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [CNT_W-1:0]     CNT_SAMPLE0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0]     CNT_SAMPLE1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0]     CNT_DECIDE    = CNT_W'(MID + 1);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(BYTE_LEN);

  logic rx_s;

  synchronizer #(
    .STAGES   (2),
    .RESET_VAL(1'b1)
  ) u_rxd_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (rxd),
    .q_o    (rx_s)
  );

  rx_state_e           state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q,   bit_idx_d;
  logic [1:0]           samp_q,      samp_d;
  logic [BYTE_LEN-1:0]  shreg_q,     shreg_d;
  logic [BYTE_LEN-1:0]  out_q,       out_d;
  logic                 out_ready_q, out_ready_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_q,     break_d;

  logic decide;
  logic bit_val;

  // The third vote is the live synchronised line on the decision cycle.
  assign decide  = (cnt_q == CNT_DECIDE);
  assign bit_val = majority3(samp_q[0], samp_q[1], rx_s);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    samp_d      = samp_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    out_ready_d = 1'b0;
    frame_err_d = 1'b0;
    break_d     = break_q;

    if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        bit_idx_d = bit_idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == CNT_SAMPLE0) samp_d[0] = rx_s;
      if (cnt_q == CNT_SAMPLE1) samp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_idx_d = '0;
          shreg_d   = '0;
        end
      end
      ST_START: begin
        if (decide) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide) begin
          shreg_d = {bit_val, shreg_q[BYTE_LEN-1:1]};
          if (bit_idx_q == LAST_DATA_IDX) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit of margin for the next start edge.
        if (decide) begin
          if (bit_val) begin
            out_d       = shreg_q;
            out_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            break_d     = (shreg_q == '0);
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          break_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      samp_q      <= '1;
      shreg_q     <= '0;
      out_q       <= '0;
      out_ready_q <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      samp_q      <= samp_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      out_ready_q <= out_ready_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
    end
  end

  assign out       = out_q;
  assign out_ready = out_ready_q;
  assign frame_err = frame_err_q;
  assign break_det = break_q;

endmodule

// File: tb/tb_uart_rx_driver.sv
// Bench for uart_rx_driver: per-segment line waveforms decoded by a software UART model.
module tb_uart_rx_driver;

  localparam int BP   = 16;
  localparam int MID  = BP / 2;
  localparam int MAXC = 4096;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd     = 1'b1;
  logic [7:0] out;
  logic       out_ready;
  logic       frame_err;
  logic       break_det;

  uart_rx_driver #(.BAUD_PERIOD(BP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .out      (out),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .break_det(break_det)
  );

  always #5 clk = ~clk;

  logic       line    [MAXC];
  int         len;
  logic       exp_rdy [MAXC];
  logic       exp_fe  [MAXC];
  logic       exp_brk [MAXC];
  logic [7:0] exp_out [MAXC];
  logic       act_rdy [MAXC];
  logic       act_fe  [MAXC];
  logic       act_brk [MAXC];
  logic [7:0] act_out [MAXC];

  int checks;
  int failures;
  bit running;
  int cyc;

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%02h expected=0x%02h", name, c, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      act_rdy[cyc] = out_ready;
      act_fe[cyc]  = frame_err;
      act_brk[cyc] = break_det;
      act_out[cyc] = out;
      chk("out_ready", cyc, 8'(out_ready), 8'(exp_rdy[cyc]));
      chk("frame_err", cyc, 8'(frame_err), 8'(exp_fe[cyc]));
      chk("break_det", cyc, 8'(break_det), 8'(exp_brk[cyc]));
      chk("out",       cyc, out,           exp_out[cyc]);
    end
  end

  task automatic push(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      line[len] = v;
      len++;
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input logic stop_v, input int bl,
                            input bit glitch, input bit any_pos);
    for (int k = 0; k < 10; k++) begin
      logic v;
      int   gp;
      v  = (k == 0) ? 1'b0 : (k == 9) ? stop_v : b[k-1];
      gp = any_pos ? int'($urandom_range(bl - 1, 0)) : int'($urandom_range(bl - 2, 1));
      for (int j = 0; j < bl; j++) begin
        line[len] = (glitch && j == gp) ? ~v : v;
        len++;
      end
    end
  endtask

  // Synchronised view of the pin: two cycles late, idle-high out of reset.
  function automatic logic rs(input int c);
    return (c < 2) ? 1'b1 : line[c-2];
  endfunction

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  task automatic build_expect();
    int         c;
    logic [7:0] cur;
    for (int i = 0; i < len; i++) begin
      exp_rdy[i] = 1'b0;
      exp_fe[i]  = 1'b0;
      exp_brk[i] = 1'b0;
      exp_out[i] = 8'h00;
    end
    c = 0;
    while (c < len) begin
      if (rs(c)) begin
        c++;
      end else begin
        int         t0;
        int         d;
        logic [9:0] bits;
        bit         aborted;
        bit         false_start;
        t0 = c; d = c; bits = '0; aborted = 0; false_start = 0;
        for (int k = 0; k < 10 && !aborted && !false_start; k++) begin
          d = t0 + 1 + k * BP + MID + 1;
          if (d >= len) aborted = 1;
          else begin
            bits[k] = maj(rs(d - 2), rs(d - 1), rs(d));
            if (k == 0 && bits[0]) false_start = 1;
          end
        end
        if (aborted) c = len;
        else if (false_start) c = d + 1;
        else begin
          logic [7:0] byte_v;
          int         w;
          byte_v = bits[8:1];
          if (bits[9]) begin
            if (d + 1 < len) begin
              exp_rdy[d+1] = 1'b1;
              exp_out[d+1] = byte_v;
            end
            c = d + 1;
          end else begin
            if (d + 1 < len) exp_fe[d+1] = 1'b1;
            w = d + 1;
            while (w < len && !rs(w)) begin
              exp_brk[w] = (byte_v == 8'h00);
              w++;
            end
            if (w < len) exp_brk[w] = (byte_v == 8'h00);
            c = w + 1;
          end
        end
      end
    end
    cur = 8'h00;
    for (int i = 0; i < len; i++) begin
      if (exp_rdy[i]) cur = exp_out[i];
      exp_out[i] = cur;
    end
  endtask

  task automatic run_segment();
    build_expect();
    @(posedge clk); #1;
    reset_n = 1'b0;
    rxd     = 1'b1;
    @(negedge clk);
    chk("reset_out",       -1, out,              8'h00);
    chk("reset_out_ready", -1, 8'(out_ready),    8'h00);
    chk("reset_frame_err", -1, 8'(frame_err),    8'h00);
    chk("reset_break_det", -1, 8'(break_det),    8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int n = 0; n < len; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      cyc     = n;
      rxd     = line[n];
      running = 1;
    end
    @(posedge clk); #1;
    running = 0;
  endtask

  task automatic tally(output int nr, output int nf, output int nb, output logic [7:0] last_out);
    nr = 0; nf = 0; nb = 0;
    for (int i = 0; i < len; i++) begin
      if (act_rdy[i]) nr++;
      if (act_fe[i])  nf++;
      if (act_brk[i]) nb++;
    end
    last_out = act_out[len-1];
  endtask

  initial begin
    int         nr;
    int         nf;
    int         nb;
    logic [7:0] lo;
    checks = 0; failures = 0; running = 0; cyc = 0;

    // 1: nominal 0xA5, start edge at line cycle 7 -> t0 = 9, pulse at 9 + 155
    len = 0; push(1'b1, 7); push_frame(8'hA5, 1'b1, BP, 0, 0); push(1'b1, 2 * BP);
    run_segment();
    tally(nr, nf, nb, lo);
    chk("s1_model_pulse", 164, 8'(exp_rdy[164]), 8'h01);
    chk("s1_pulse",       164, 8'(act_rdy[164]), 8'h01);
    chk("s1_value",       164, act_out[164],     8'hA5);
    chk("s1_pulses",       -1, 8'(nr),           8'd1);
    chk("s1_frame_errs",   -1, 8'(nf),           8'd0);

    // 2: 0x00 then 0xFF with no idle gap, pulses 160 apart
    len = 0; push(1'b1, 5); push_frame(8'h00, 1'b1, BP, 0, 0); push_frame(8'hFF, 1'b1, BP, 0, 0);
    push(1'b1, 2 * BP);
    run_segment();
    tally(nr, nf, nb, lo);
    chk("s2_pulse_a",  162, 8'(act_rdy[162]), 8'h01);
    chk("s2_value_a",  162, act_out[162],     8'h00);
    chk("s2_pulse_b",  322, 8'(act_rdy[322]), 8'h01);
    chk("s2_value_b",  322, act_out[322],     8'hFF);
    chk("s2_pulses",    -1, 8'(nr),           8'd2);

    // 3: 5-cycle false start, then 0x3C
    len = 0; push(1'b1, 4); push(1'b0, 5); push(1'b1, 30); push_frame(8'h3C, 1'b1, BP, 0, 0);
    push(1'b1, 2 * BP);
    run_segment();
    tally(nr, nf, nb, lo);
    chk("s3_pulses",     -1, 8'(nr), 8'd1);
    chk("s3_frame_errs", -1, 8'(nf), 8'd0);
    chk("s3_value",      -1, lo,     8'h3C);

    // 4: 0x55 with low stop bit, then 0x12
    len = 0; push(1'b1, 4); push_frame(8'h55, 1'b0, BP, 0, 0); push(1'b1, 20);
    push_frame(8'h12, 1'b1, BP, 0, 0); push(1'b1, 2 * BP);
    run_segment();
    tally(nr, nf, nb, lo);
    chk("s4_frame_errs", -1, 8'(nf), 8'd1);
    chk("s4_pulses",     -1, 8'(nr), 8'd1);
    chk("s4_break",      -1, 8'(nb), 8'd0);
    chk("s4_value",      -1, lo,     8'h12);

    // 5: line low for 30 bit times, pin rises at line cycle 484
    len = 0; push(1'b1, 4); push(1'b0, 30 * BP); push(1'b1, 40);
    run_segment();
    tally(nr, nf, nb, lo);
    chk("s5_model_brk_hi", 486, 8'(exp_brk[486]), 8'h01);
    chk("s5_model_brk_lo", 487, 8'(exp_brk[487]), 8'h00);
    chk("s5_frame_err",    161, 8'(act_fe[161]),  8'h01);
    chk("s5_frame_errs",    -1, 8'(nf),           8'd1);
    chk("s5_brk_hi",       486, 8'(act_brk[486]), 8'h01);
    chk("s5_brk_lo",       487, 8'(act_brk[487]), 8'h00);
    chk("s5_pulses",        -1, 8'(nr),           8'd0);

    // 6: 0xC3 cut off mid data bit 4 by reset, then 0x81 with a glitch in every bit
    len = 0; push(1'b1, 4); push_frame(8'hC3, 1'b1, BP, 0, 0); len = 4 + 4 * BP + MID;
    run_segment();
    tally(nr, nf, nb, lo);
    chk("s6a_pulses",     -1, 8'(nr), 8'd0);
    chk("s6a_frame_errs", -1, 8'(nf), 8'd0);
    len = 0; push(1'b1, 4); push_frame(8'h81, 1'b1, BP, 1, 0); push(1'b1, 2 * BP);
    run_segment();
    tally(nr, nf, nb, lo);
    chk("s6b_pulse",  161, 8'(act_rdy[161]), 8'h01);
    chk("s6b_pulses",  -1, 8'(nr),           8'd1);
    chk("s6b_value",   -1, lo,               8'h81);

    // Random traffic: bytes, gaps, glitches, bit-length skew, bad stops, runts
    for (int s = 0; s < 3; s++) begin
      len = 0;
      push(1'b1, 3);
      for (int f = 0; f < 10; f++) begin
        logic [7:0] b;
        b = ($urandom_range(5, 0) == 0) ? 8'h00 : 8'($urandom);
        if ($urandom_range(5, 0) == 0) begin
          push(1'b0, int'($urandom_range(12, 1)));
          push(1'b1, int'($urandom_range(20, 1)));
        end
        push_frame(b, ($urandom_range(7, 0) != 0), int'($urandom_range(BP + 1, BP - 1)),
                   ($urandom_range(1, 0) == 1), 1);
        push(1'b1, int'($urandom_range(24, 0)));
      end
      push(1'b1, 2 * BP);
      run_segment();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
